// File: rtl/sopc_data_bridge.sv
// sopc_data_bridge: address-decoded data bus bridge from the OpenMIPS CPU to NUM_SLV wait-state/ack slaves
module sopc_data_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_SLV = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {32'hF000_0000, 32'hF000_0000},
  parameter logic [NUM_SLV*4-1:0] SLV_WAIT = {4'd3, 4'd0},
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_ce_i,
  input  logic                      cpu_we_i,
  input  logic [ADDR_W-1:0]         cpu_addr_i,
  input  logic [DATA_W/8-1:0]       cpu_sel_i,
  input  logic [DATA_W-1:0]         cpu_data_i,
  output logic [DATA_W-1:0]         cpu_data_o,
  output logic                      cpu_stall_o,
  output logic                      cpu_err_o,
  output logic [NUM_SLV-1:0]        s_ce_o,
  output logic                      s_we_o,
  output logic [ADDR_W-1:0]         s_addr_o,
  output logic [DATA_W/8-1:0]       s_sel_o,
  output logic [DATA_W-1:0]         s_data_o,
  input  logic [NUM_SLV*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLV-1:0]        s_ack_i
);
  localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, nxt;
  logic hit, err_q, fin, tmo;
  logic [IW-1:0] idx, idx_q;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] cap_q, lane_mask;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if ((cpu_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
  for (genvar b = 0; b < DATA_W / 8; b++) assign lane_mask[b*8 +: 8] = {8{s_sel_o[b]}};
  assign fin = state == ACCESS && 32'(cnt) >= 32'(SLV_WAIT[idx_q*4 +: 4]) && s_ack_i[idx_q];
  assign tmo = state == ACCESS && !fin && 32'(cnt) >= 32'(TIMEOUT - 1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (cpu_ce_i ? (hit ? ACCESS : DONE) : IDLE) :
          state == ACCESS ? (fin || tmo ? DONE : ACCESS) : IDLE;
  always_comb begin
    cpu_stall_o = cpu_ce_i && state != DONE;
    cpu_err_o = state == DONE && err_q;
    cpu_data_o = state == DONE && !err_q ? cap_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ce_o <= '0;
      s_we_o <= 1'b0;
      s_addr_o <= '0;
      s_sel_o <= '0;
      s_data_o <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      cap_q <= '0;
      cnt <= '0;
    end else if (state == IDLE && cpu_ce_i) begin
      s_ce_o <= hit ? (NUM_SLV'(1) << idx) : '0;
      s_we_o <= cpu_we_i;
      s_addr_o <= cpu_addr_i;
      s_sel_o <= cpu_sel_i;
      s_data_o <= cpu_data_i;
      idx_q <= idx;
      err_q <= !hit;
      cap_q <= '0;
      cnt <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + CW'(cnt != CW'(TIMEOUT));
      if (fin || tmo) s_ce_o <= '0;
      if (fin) cap_q <= s_we_o ? '0 : s_data_i[idx_q*DATA_W +: DATA_W] & lane_mask;
      if (tmo) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sopc_data_bridge.sv
// tb_sopc_data_bridge: table-driven, scoreboarded checks of sopc_data_bridge decode, wait states, errors and timing
module tb_sopc_data_bridge;
  logic clk, rst, cpu_ce_i, cpu_we_i, cpu_stall_o, cpu_err_o, s_we_o;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o, s_addr_o, s_data_o;
  logic [3:0] cpu_sel_i, s_sel_o;
  logic [1:0] s_ce_o, s_ack_i;
  logic [63:0] s_data_i;
  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [3:0] sel;
    logic [31:0] wdata;
    logic [31:0] sd0;
    logic [31:0] sd1;
    logic [1:0] ack;
    logic [31:0] exp_data;
    logic exp_err;
    int exp_stall;
    logic [1:0] exp_ce;
    int exp_cec;
  } vec_t;
  vec_t vecs[10];
  vec_t sb[$];
  int n_cmp = 0, n_bad = 0, cur = 0;
  int dc[2];
  logic [31:0] dd[2];
  sopc_data_bridge dut (
    .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .cpu_err_o(cpu_err_o), .s_ce_o(s_ce_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o),
    .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (case %0d): got %h expected %h", nm, cur, got, exp);
    end
  endtask
  task automatic do_vec(input vec_t v);
    vec_t e;
    int cyc, stall_n, ce_n, early;
    logic [1:0] ce_or;
    logic done, ge, gwe;
    logic [31:0] gd, ga, gw;
    logic [3:0] gs;
    cyc = 0; stall_n = 0; ce_n = 0; early = 0; ce_or = '0; done = 1'b0;
    ge = 1'b0; gwe = 1'b0; gd = '0; ga = '0; gw = '0; gs = '0;
    s_data_i = {v.sd1, v.sd0};
    s_ack_i = v.ack;
    cpu_we_i = v.we;
    cpu_addr_i = v.addr;
    cpu_sel_i = v.sel;
    cpu_data_i = v.wdata;
    cpu_ce_i = 1'b1;
    sb.push_back(v);
    while (!done && cyc < 40) begin
      #1;
      if (cpu_stall_o) begin
        stall_n++;
        if (cpu_err_o || cpu_data_o != 0) early++;
      end
      if (s_ce_o != 0) begin
        if (ce_n == 0) begin
          gwe = s_we_o; ga = s_addr_o; gs = s_sel_o; gw = s_data_o;
        end
        ce_n++;
        ce_or = ce_or | s_ce_o;
      end
      if (!cpu_stall_o) begin
        done = 1'b1;
        gd = cpu_data_o;
        ge = cpu_err_o;
      end
      @(negedge clk);
      cyc++;
    end
    cpu_ce_i = 1'b0;
    e = sb.pop_front();
    check("done_seen", 32'(done), 32'(1));
    check("stall_cycles", stall_n, e.exp_stall);
    check("ce_cycles", ce_n, e.exp_cec);
    check("ce_onehot", 32'(ce_or), 32'(e.exp_ce));
    check("rdata", gd, e.exp_data);
    check("err", 32'(ge), 32'(e.exp_err));
    check("no_early_result", early, 0);
    if (e.exp_cec > 0) begin
      check("s_we", 32'(gwe), 32'(e.we));
      check("s_addr", ga, e.addr);
      check("s_sel", 32'(gs), 32'(e.sel));
      check("s_wdata", gw, e.wdata);
    end
    #1;
    check("post_done_err", 32'(cpu_err_o), 32'(0));
    check("post_done_data", cpu_data_o, 32'h0);
    @(negedge clk);
  endtask
  initial begin
    int errs, nd;
    vecs[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 32'h0, 2'b11, 32'hDEAD_BEEF, 1'b0, 2, 2'b01, 1};
    vecs[1] = '{1'b1, 32'h1000_0004, 4'b0011, 32'h1234_5678, 32'h0, 32'h0, 2'b11, 32'h0, 1'b0, 5, 2'b10, 4};
    vecs[2] = '{1'b0, 32'h1000_0008, 4'b1100, 32'h0, 32'h0, 32'hAABB_CCDD, 2'b11, 32'hAABB_0000, 1'b0, 5, 2'b10, 4};
    vecs[3] = '{1'b0, 32'h2000_0000, 4'hF, 32'h0, 32'h1111_1111, 32'h2222_2222, 2'b11, 32'h0, 1'b1, 1, 2'b00, 0};
    vecs[4] = '{1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b10, 32'h0, 1'b1, 16, 2'b01, 15};
    vecs[5] = '{1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b11, 32'h0, 1'b0, 2, 2'b01, 1};
    vecs[6] = '{1'b0, 32'h1FFF_FFFC, 4'b1001, 32'h0, 32'h0, 32'h1122_3344, 2'b11, 32'h1100_0044, 1'b0, 5, 2'b10, 4};
    vecs[7] = '{1'b1, 32'h0FFF_FFFC, 4'hF, 32'hCAFE_F00D, 32'h9999_9999, 32'h0, 2'b11, 32'h0, 1'b0, 2, 2'b01, 1};
    vecs[8] = '{1'b0, 32'h1000_0000, 4'hF, 32'h0, 32'h0, 32'h7777_7777, 2'b01, 32'h0, 1'b1, 16, 2'b10, 15};
    vecs[9] = '{1'b0, 32'h0FFF_FFFC, 4'b0110, 32'h0, 32'hCAFE_F00D, 32'h0, 2'b11, 32'h00FE_F000, 1'b0, 2, 2'b01, 1};
    rst = 1'b1; cpu_ce_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
    s_data_i = '0; s_ack_i = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ce", 32'(s_ce_o), 32'(0));
    check("rst_s_we", 32'(s_we_o), 32'(0));
    check("rst_s_addr", s_addr_o, 32'h0);
    check("rst_s_sel", 32'(s_sel_o), 32'(0));
    check("rst_s_data", s_data_o, 32'h0);
    check("rst_cpu_data", cpu_data_o, 32'h0);
    check("rst_cpu_err", 32'(cpu_err_o), 32'(0));
    check("rst_stall", 32'(cpu_stall_o), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      cur = i;
      do_vec(vecs[i]);
    end
    cur = 100;
    s_data_i = {32'h0BAD_0BAD, 32'h0}; s_ack_i = 2'b11; cpu_we_i = 1'b0;
    cpu_addr_i = 32'h1000_0000; cpu_sel_i = 4'hF; cpu_ce_i = 1'b1;
    @(negedge clk);
    #1 check("rstseq_ce_cnt0", 32'(s_ce_o), 32'(2'b10));
    @(negedge clk);
    rst = 1'b1; cpu_ce_i = 1'b0;
    #1 check("rstseq_ce_cnt1", 32'(s_ce_o), 32'(2'b10));
    check("rstseq_err_cnt1", 32'(cpu_err_o), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 check("rstseq_ce_after", 32'(s_ce_o), 32'(0));
    check("rstseq_err_after", 32'(cpu_err_o), 32'(0));
    errs = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (cpu_err_o || cpu_data_o != 0 || s_ce_o != 0) errs++;
    end
    check("rstseq_quiet", errs, 0);
    @(negedge clk);
    cur = 101;
    s_data_i = {32'h0, 32'h5555_AAAA}; cpu_addr_i = 32'h0000_0040; cpu_sel_i = 4'hF; cpu_ce_i = 1'b1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (!cpu_stall_o) begin
        if (nd < 2) begin
          dc[nd] = c;
          dd[nd] = cpu_data_o;
        end
        nd++;
      end
      @(negedge clk);
    end
    cpu_ce_i = 1'b0;
    check("b2b_done_count", nd, 2);
    check("b2b_first_done", dc[0], 2);
    check("b2b_spacing", dc[1] - dc[0], 3);
    check("b2b_data0", dd[0], 32'h5555_AAAA);
    check("b2b_data1", dd[1], 32'h5555_AAAA);
    repeat (3) @(negedge clk);
    cur = 102;
    s_data_i = {32'h8765_4321, 32'h0}; cpu_addr_i = 32'h1000_0010; cpu_sel_i = 4'hF; cpu_ce_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    #1 check("drop_stall", 32'(cpu_stall_o), 32'(0));
    check("drop_ce_held", 32'(s_ce_o), 32'(2'b10));
    @(negedge clk);
    @(negedge clk);
    #1 check("drop_data_pre", cpu_data_o, 32'h0);
    @(negedge clk);
    #1 check("drop_data_done", cpu_data_o, 32'h8765_4321);
    check("drop_err_done", 32'(cpu_err_o), 32'(0));
    @(negedge clk);
    #1 check("drop_data_post", cpu_data_o, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sopc_data_bridge.md
Name: sopc_data_bridge

Overview:
- Parametrised data-side interconnect for the OpenMIPS SOPC.
- Replaces the single direct CPU-to-data_ram connection with an address-decoded bridge to NUM_SLV slaves.
- Per-slave wait states and an ack handshake let each slave take a different number of cycles.
- Stalls the CPU until the access completes; flags unmapped addresses and slave timeouts as bus errors.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8; byte lanes = DATA_W/8.
- NUM_SLV, 2, number of slave regions (1..8).
- SLV_BASE, {32'h1000_0000, 32'h0000_0000}, packed NUM_SLV*ADDR_W base addresses; slave i occupies slice i.
- SLV_MASK, {32'hF000_0000, 32'hF000_0000}, packed NUM_SLV*ADDR_W decode masks.
- SLV_WAIT, {4'd3, 4'd0}, packed NUM_SLV*4 minimum wait states per slave.
- TIMEOUT, 15, maximum ACCESS cycles before an error; must be greater than every SLV_WAIT entry.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- cpu_ce_i, in, 1, data access request; held by the CPU while stalled.
- cpu_we_i, in, 1, 1 = write, 0 = read.
- cpu_addr_i, in, ADDR_W, byte address.
- cpu_sel_i, in, DATA_W/8, byte-lane enables.
- cpu_data_i, in, DATA_W, write data.
- cpu_data_o, out, DATA_W, read data; valid in the DONE cycle.
- cpu_stall_o, out, 1, stall request to the pipeline.
- cpu_err_o, out, 1, bus error pulse.
- s_ce_o, out, NUM_SLV, one-hot slave chip enable.
- s_we_o, out, 1, slave write enable (shared by all slaves).
- s_addr_o, out, ADDR_W, latched address (shared).
- s_sel_o, out, DATA_W/8, latched byte lanes (shared).
- s_data_o, out, DATA_W, latched write data (shared).
- s_data_i, in, NUM_SLV*DATA_W, packed slave read data.
- s_ack_i, in, NUM_SLV, slave ready; tie to 1 for a fixed-latency slave.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state = IDLE; cpu_data_o = 0; cpu_err_o = 0; s_ce_o = 0; s_we_o = 0; s_addr_o = 0; s_sel_o = 0; s_data_o = 0; wait counter = 0.
- Decode: slave i matches when (cpu_addr_i & MASK_i) == BASE_i. On overlapping regions the lowest index wins. No match means unmapped.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when cpu_ce_i = 1, latch we/addr/sel/data into the s_* registers and the decoded index.
  - Mapped address: next state ACCESS; s_ce_o[idx] = 1; counter = 0.
  - Unmapped address: next state DONE with the error flag set; s_ce_o stays 0.
- ACCESS: s_ce_o[idx] is held and the counter increments each cycle.
  - Completes when counter >= SLV_WAIT[idx] and s_ack_i[idx] = 1.
  - On completion: for a read, capture s_data_i slice idx with unselected byte lanes forced to 0; clear s_ce_o; go to DONE.
  - Timeout: if counter reaches TIMEOUT without completion, clear s_ce_o and go to DONE with the error flag set.
- DONE (exactly one cycle): cpu_data_o is driven from the capture register; cpu_err_o = error flag; next state IDLE.
  - Write or error: cpu_data_o = 0.
- cpu_data_o and cpu_err_o return to 0 in every cycle that is not DONE.
- Stall: cpu_stall_o = cpu_ce_i && (state != DONE), combinational.
- Latency with ack tied high and wait W: the stall is high for W+2 cycles, the DONE cycle is W+2 cycles after the request is first seen, and the slave sees W+1 ce cycles.
- Back-to-back: DONE -> IDLE costs one idle cycle. A request still asserted in that IDLE cycle starts a new access.
- cpu_ce_i dropping mid-ACCESS: the slave access runs to completion (no abort). The DONE result is still driven, but the stall is already low.
- Reset during ACCESS or DONE: immediate return to IDLE; s_ce_o drops in the reset cycle's next edge; no error is reported.
- cpu_sel_i = 0 is a legal access: it is forwarded unchanged and read data is all zero.
- Write data and sel are forwarded unmodified; byte steering is the slave's job.
- The counter width holds TIMEOUT without wrap; it saturates and never wraps.

Test Plan:
- Read slave0 (W=0, ack=1) at 0x0000_0010 with sel=4'hF, slave data 0xDEAD_BEEF -> stall high 2 cycles; DONE shows cpu_data_o = 0xDEAD_BEEF, err = 0; s_ce_o = 2'b01 for 1 cycle.
- Write to slave1 (W=3) at 0x1000_0004 with data 0x1234_5678, sel=4'b0011 -> s_ce_o = 2'b10 for 4 cycles with s_we_o = 1 and s_sel_o = 4'b0011; stall high 5 cycles; DONE with cpu_data_o = 0.
- Read slave1 with sel=4'b1100 and slave data 0xAABB_CCDD -> cpu_data_o = 0xAABB_0000.
- Read unmapped 0x2000_0000 -> no s_ce_o; stall 1 cycle; DONE with err = 1 and data = 0.
- Slave0 with ack held 0 -> after 15 ACCESS cycles, DONE with err = 1; then return to IDLE.
- Assert rst during slave1 ACCESS at counter = 1 -> next cycle state IDLE, s_ce_o = 0, err never asserted. Then two back-to-back reads to slave0 -> two DONE pulses 3 cycles apart.
